// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning N:1 sampler.
package mux_scan_pkg;

    // IDLE: waiting for a request; EMIT: a beat is presented on the output.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Modulo-n increment; safe for non-power-of-2 n (idx assumed < n).
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 lane select.
//   in  : packed channels, channel k = in[k*WIDTH +: WIDTH]
//   sel : channel index; out-of-range indices yield all zeros
//   out : selected lane
module mux_n #(
    parameter int unsigned N_IN  = 32,
    parameter int unsigned WIDTH = 1,
    parameter int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out
);

    // Decoded select so that a non-power-of-2 N_IN never reads past the bus.
    always_comb begin
        out = '0;
        for (int k = 0; k < int'(N_IN); k++) begin
            if (sel == SEL_W'(k)) begin
                out = in[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_scan_sampler.sv
// Sampling N:1 mux with single-shot and wrap-around scan modes on a valid/ready output.
//   clk, rst              : clock, asynchronous active-high reset
//   in                    : packed input channels
//   sel_in                : start / target channel
//   sel_load              : sample sel_in once
//   scan_start, scan_len  : sample scan_len consecutive channels from sel_in (mod N_IN)
//   abort                 : cancel current operation
//   out_data, out_sel     : registered sample and its channel index
//   out_valid, out_ready  : output handshake
//   busy                  : operation in progress
//   scan_done             : pulse on acceptance of the final scan beat
//   err                   : pulse when a request is rejected
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int unsigned N_IN  = 32,
    parameter int unsigned WIDTH = 1,
    parameter int unsigned SEL_W = $clog2(N_IN),
    parameter int unsigned LEN_W = $clog2(N_IN) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  sel_load,
    input  logic                  scan_start,
    input  logic [LEN_W-1:0]      scan_len,
    input  logic                  abort,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  scan_done,
    output logic                  err
);

    state_t             r_state;
    state_t             w_state_nx;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_nx;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nx;
    logic               r_valid;
    logic               w_valid_nx;
    logic [LEN_W-1:0]   r_rem;
    logic [LEN_W-1:0]   w_rem_nx;
    logic               r_scan;
    logic               w_scan_nx;
    logic               r_err;
    logic               w_err_nx;

    logic               w_sel_ok;
    logic               w_len_ok;
    logic               w_req;
    logic               w_req_ok;
    logic               w_hs;
    logic               w_last;
    logic [SEL_W-1:0]   w_next_idx;
    logic [SEL_W-1:0]   w_mux_sel;
    logic [WIDTH-1:0]   w_mux_out;

    // Request qualification; scan_start takes priority over sel_load.
    assign w_sel_ok   = 32'(sel_in) < N_IN;
    assign w_len_ok   = (scan_len != '0) && (32'(scan_len) <= N_IN);
    assign w_req      = scan_start | sel_load;
    assign w_req_ok   = scan_start ? (w_sel_ok && w_len_ok) : w_sel_ok;

    assign w_hs       = r_valid & out_ready;
    assign w_last     = (r_rem == '0);
    assign w_next_idx = SEL_W'(next_idx(32'(r_sel), N_IN));

    // While emitting, the mux looks ahead to the following channel so a
    // handshake can reload the output register with no bubble.
    assign w_mux_sel  = (r_state == EMIT) ? w_next_idx : sel_in;

    mux_n #(
        .N_IN  (N_IN),
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_mux (
        .in  (in),
        .sel (w_mux_sel),
        .out (w_mux_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic; abort wins over both requests and handshakes.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: if (!abort && w_req && w_req_ok) w_state_nx = EMIT;
            EMIT: if (abort || (w_hs && w_last))   w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Next values of the output / counter registers.
    always_comb begin
        w_data_nx  = r_data;
        w_sel_nx   = r_sel;
        w_valid_nx = r_valid;
        w_rem_nx   = r_rem;
        w_scan_nx  = r_scan;
        w_err_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!abort && w_req) begin
                    if (w_req_ok) begin
                        w_data_nx  = w_mux_out;
                        w_sel_nx   = sel_in;
                        w_valid_nx = 1'b1;
                        w_scan_nx  = scan_start;
                        w_rem_nx   = scan_start ? (scan_len - LEN_W'(1)) : '0;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (abort) begin
                    w_valid_nx = 1'b0;
                end else if (w_hs) begin
                    if (w_last) begin
                        w_valid_nx = 1'b0;
                    end else begin
                        w_data_nx = w_mux_out;
                        w_sel_nx  = w_next_idx;
                        w_rem_nx  = r_rem - LEN_W'(1);
                    end
                end
            end
            default: w_valid_nx = 1'b0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_rem   <= '0;
            r_scan  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_data  <= w_data_nx;
            r_sel   <= w_sel_nx;
            r_valid <= w_valid_nx;
            r_rem   <= w_rem_nx;
            r_scan  <= w_scan_nx;
            r_err   <= w_err_nx;
        end
    end

    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign out_valid = r_valid;
    assign err       = r_err;
    assign busy      = (r_state == EMIT);

    // Marks the handshake cycle of the last scan beat itself.
    assign scan_done = (r_state == EMIT) && w_hs && w_last && r_scan && !abort;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Randomised + directed bench for mux_scan_sampler (N_IN=32 with a reference model, N_IN=24 directed).
module tb_mux_scan_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Main instance, N_IN=32
    logic [31:0] in_bus = 32'hAAAAAAAA;
    logic [4:0]  sel_in = '0;
    logic        sel_load = 1'b0;
    logic        scan_start = 1'b0;
    logic [5:0]  scan_len = '0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_data;
    logic [4:0]  out_sel;
    logic        out_valid, busy, scan_done, err;

    // Second instance, N_IN=24
    logic [23:0] b_in = 24'hAAAAAA;
    logic [4:0]  b_sel = '0;
    logic        b_load = 1'b0;
    logic        b_start = 1'b0;
    logic [5:0]  b_len = '0;
    logic        b_abort = 1'b0;
    logic        b_ready = 1'b1;
    logic        b_data;
    logic [4:0]  b_osel;
    logic        b_valid, b_busy, b_done, b_err;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mux_scan_sampler #(.N_IN(32), .WIDTH(1)) dut (
        .clk(clk), .rst(rst), .in(in_bus), .sel_in(sel_in), .sel_load(sel_load),
        .scan_start(scan_start), .scan_len(scan_len), .abort(abort),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .scan_done(scan_done), .err(err)
    );

    mux_scan_sampler #(.N_IN(24), .WIDTH(1)) dut24 (
        .clk(clk), .rst(rst), .in(b_in), .sel_in(b_sel), .sel_load(b_load),
        .scan_start(b_start), .scan_len(b_len), .abort(b_abort),
        .out_data(b_data), .out_sel(b_osel), .out_valid(b_valid), .out_ready(b_ready),
        .busy(b_busy), .scan_done(b_done), .err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of channel indices still owed to the consumer;
    // front of the queue is the beat currently on the output.
    int unsigned m_q[$];
    logic        m_valid = 1'b0;
    logic        m_scan  = 1'b0;
    logic        m_err   = 1'b0;
    logic        m_data  = 1'b0;
    logic [4:0]  m_sel   = '0;

    always @(posedge clk or posedge rst) begin
        int unsigned len;
        if (rst) begin
            m_q.delete();
            m_valid = 1'b0; m_scan = 1'b0; m_err = 1'b0; m_data = 1'b0; m_sel = '0;
        end else begin
            m_err = 1'b0;
            if (m_valid) begin
                if (abort) begin
                    m_q.delete();
                    m_valid = 1'b0;
                end else if (out_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_valid = 1'b0;
                    end else begin
                        m_sel  = 5'(m_q[0]);
                        m_data = in_bus[m_q[0]];
                    end
                end
            end else if (!abort && (scan_start || sel_load)) begin
                len = scan_start ? int'(scan_len) : 1;
                if (len < 1 || len > 32) begin
                    m_err = 1'b1;
                end else begin
                    m_scan = scan_start;
                    for (int k = 0; k < int'(len); k++) m_q.push_back((int'(sel_in) + k) % 32);
                    m_valid = 1'b1;
                    m_sel   = sel_in;
                    m_data  = in_bus[sel_in];
                end
            end
        end
    end

    // Every-cycle comparison against the model, after inputs settle.
    always @(negedge clk) begin
        #2;
        chk("valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_valid));
        chk("err", 32'(err), 32'(m_err));
        chk("scan_done", 32'(scan_done),
            32'(m_valid && out_ready && !abort && m_scan && (m_q.size() == 1)));
        if (m_valid) begin
            chk("data", 32'(out_data), 32'(m_data));
            chk("sel", 32'(out_sel), 32'(m_sel));
        end
    end

    task automatic nclk();
        @(negedge clk);
    endtask

    initial begin
        int r;
        #1 rst = 1'b1;
        nclk(); nclk();
        rst = 1'b0;
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_sel", 32'(out_sel), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // manual sel 0
        nclk(); sel_in = 5'd0; sel_load = 1'b1;
        nclk(); sel_load = 1'b0; #1;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'd0);
        chk("t1_sel", 32'(out_sel), 32'd0);
        chk("t1_done", 32'(scan_done), 32'd0);
        nclk(); #1;
        chk("t1_idle", 32'(busy), 32'd0);

        // manual sel 31
        nclk(); sel_in = 5'd31; sel_load = 1'b1;
        nclk(); sel_load = 1'b0; #1;
        chk("t2_data", 32'(out_data), 32'd1);
        chk("t2_sel", 32'(out_sel), 32'd31);
        nclk(); #1;
        chk("t2_idle", 32'(busy), 32'd0);

        // scan 30 len 4 with wrap
        nclk(); sel_in = 5'd30; scan_len = 6'd4; scan_start = 1'b1;
        nclk(); scan_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nclk();
            #1;
            chk("t3_sel", 32'(out_sel), 32'((30 + k) % 32));
            chk("t3_data", 32'(out_data), 32'(((30 + k) % 32) & 1));
            chk("t3_done", 32'(scan_done), 32'(k == 3));
        end
        nclk(); #1;
        chk("t3_end", 32'(out_valid), 32'd0);

        // stall on beat 2, input changes during the stall
        nclk(); scan_start = 1'b1;
        nclk(); scan_start = 1'b0; #1;
        chk("t4_b1", 32'(out_sel), 32'd30);
        nclk(); out_ready = 1'b0; #1;
        chk("t4_b2_sel", 32'(out_sel), 32'd31);
        nclk(); #1;
        chk("t4_hold_data", 32'(out_data), 32'd1);
        nclk(); in_bus = 32'd0; #1;
        chk("t4_hold_sel", 32'(out_sel), 32'd31);
        nclk(); out_ready = 1'b1; #1;
        chk("t4_held_data", 32'(out_data), 32'd1);
        chk("t4_no_done", 32'(scan_done), 32'd0);
        nclk(); #1;
        chk("t4_b3_sel", 32'(out_sel), 32'd0);
        nclk(); #1;
        chk("t4_b4_sel", 32'(out_sel), 32'd1);
        chk("t4_b4_data", 32'(out_data), 32'd0);
        chk("t4_b4_done", 32'(scan_done), 32'd1);
        nclk(); #1;
        chk("t4_end", 32'(out_valid), 32'd0);

        // abort on beat 2
        in_bus = 32'hAAAAAAAA;
        nclk(); scan_start = 1'b1;
        nclk(); scan_start = 1'b0;
        nclk(); abort = 1'b1; #1;
        chk("t6_abort_done", 32'(scan_done), 32'd0);
        nclk(); abort = 1'b0; #1;
        chk("t6_abort_valid", 32'(out_valid), 32'd0);
        chk("t6_abort_busy", 32'(busy), 32'd0);

        // reset mid-scan, then manual sel 5 with in=0
        in_bus = 32'd0;
        nclk(); scan_start = 1'b1;
        nclk(); scan_start = 1'b0;
        nclk(); rst = 1'b1; #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_sel", 32'(out_sel), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        nclk(); rst = 1'b0; sel_in = 5'd5; sel_load = 1'b1;
        nclk(); sel_load = 1'b0; #1;
        chk("t6_post_valid", 32'(out_valid), 32'd1);
        chk("t6_post_sel", 32'(out_sel), 32'd5);
        chk("t6_post_data", 32'(out_data), 32'd0);
        nclk();

        // N_IN=24: bad select, bad length, full-length wrapping scan
        nclk(); b_sel = 5'd25; b_load = 1'b1;
        nclk(); b_load = 1'b0; #1;
        chk("n24_err_sel", 32'(b_err), 32'd1);
        chk("n24_err_valid", 32'(b_valid), 32'd0);
        nclk(); #1;
        chk("n24_err_pulse", 32'(b_err), 32'd0);
        nclk(); b_sel = 5'd3; b_len = 6'd0; b_start = 1'b1;
        nclk(); b_start = 1'b0; #1;
        chk("n24_err_len", 32'(b_err), 32'd1);
        chk("n24_len_busy", 32'(b_busy), 32'd0);
        nclk(); b_sel = 5'd23; b_len = 6'd24; b_start = 1'b1;
        nclk(); b_start = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) nclk();
            #1;
            chk("n24_sel", 32'(b_osel), 32'((23 + k) % 24));
            chk("n24_data", 32'(b_data), 32'(((23 + k) % 24) & 1));
            chk("n24_done", 32'(b_done), 32'(k == 23));
        end
        nclk(); #1;
        chk("n24_end", 32'(b_valid), 32'd0);

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            nclk();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            in_bus     = $urandom;
            sel_in     = 5'($urandom);
            scan_len   = 6'($urandom_range(0, 34));
            r          = int'($urandom_range(0, 9));
            scan_start = (r < 2);
            sel_load   = (r == 2 || r == 3);
            out_ready  = ($urandom_range(0, 3) != 0);
            abort      = ($urandom_range(0, 49) == 0);
        end

        nclk();
        rst = 1'b0; scan_start = 1'b0; sel_load = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (40) nclk();
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
